// File: rtl/asmd_count_pkg.sv
// Shared types and constants for the start/count/flag controller.
// Holds the state encoding, default parameters and the parameter range check.
package asmd_count_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_E_BIT = 2;

   localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
   localparam logic [1:0] ST_COUNT_ENC = 2'b01;
   localparam logic [1:0] ST_DONE_ENC  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE_ENC,
      S_COUNT = ST_COUNT_ENC,
      S_DONE  = ST_DONE_ENC
   } state_t;

   // True when the counter width is supported and E_BIT addresses a counter bit.
   function automatic logic e_bit_in_range(input int width, input int e_bit);
      return (width >= 32'sd2) && (width <= 32'sd16) &&
             (e_bit >= 32'sd0) && (e_bit < width);
   endfunction

endpackage

// File: rtl/asmd_count_ctrl_if.sv
// Host-side bus of the controller: run control in, counter/flags/status out.
// The host drives the master modport; the controller uses the slave modport.
interface asmd_count_ctrl_if
   import asmd_count_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             start;
   logic             abort;
   logic             hold;
   logic [WIDTH-1:0] term_mask;
   logic [WIDTH-1:0] a;
   logic             e;
   logic             f;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, hold, term_mask,
      input  a, e, f, busy, done
   );

   modport slave (
      input  start, abort, hold, term_mask,
      output a, e, f, busy, done
   );
endinterface

// File: rtl/asmd_count_dp.sv
// Datapath of the controller: counter A, flag E, flag F and the latched
// termination mask. Every register moves only on a control strobe.
module asmd_count_dp
   import asmd_count_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int E_BIT = DEF_E_BIT
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             clr_a_f_i,
   input  logic             incr_a_i,
   input  logic             load_e_i,
   input  logic             set_f_i,
   input  logic [WIDTH-1:0] term_mask_i,
   output logic [WIDTH-1:0] a_o,
   output logic             e_o,
   output logic             f_o,
   output logic             match_o
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             e_q, e_d;
   logic             f_q, f_d;

   // Next-state of the datapath registers from the control strobes.
   always_comb begin
      a_d    = a_q;
      mask_d = mask_q;
      e_d    = e_q;
      f_d    = f_q;
      if (clr_a_f_i) begin
         // A run starts: E deliberately keeps its last value.
         a_d    = ZERO;
         f_d    = 1'b0;
         mask_d = term_mask_i;
      end else begin
         if (incr_a_i) begin
            a_d = a_q + ONE;
         end else begin
            a_d = a_q;
         end
         if (load_e_i) begin
            e_d = a_q[E_BIT];
         end else begin
            e_d = e_q;
         end
         if (set_f_i) begin
            f_d = 1'b1;
         end else begin
            f_d = f_q;
         end
      end
   end

   // Datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         a_q    <= ZERO;
         mask_q <= ZERO;
         e_q    <= 1'b0;
         f_q    <= 1'b0;
      end else begin
         a_q    <= a_d;
         mask_q <= mask_d;
         e_q    <= e_d;
         f_q    <= f_d;
      end
   end

   // Termination test on the current (pre-increment) counter value.
   assign match_o = ((a_q & mask_q) == mask_q);
   assign a_o     = a_q;
   assign e_o     = e_q;
   assign f_o     = f_q;

endmodule

// File: rtl/asmd_count_ctrl.sv
// Three-state start/count/done controller with its datapath.
// Counts A from zero until A covers the latched mask, with abort and hold,
// and reports busy plus a one-cycle done strobe decoded from the state register.
module asmd_count_ctrl
   import asmd_count_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int E_BIT = DEF_E_BIT
) (
   input  logic             clk,
   input  logic             rst_b,
   asmd_count_ctrl_if.slave bus
);

   if (!e_bit_in_range(WIDTH, E_BIT)) begin : g_param_check
      $error("asmd_count_ctrl: WIDTH must be 2..16 and E_BIT must be below WIDTH");
   end

   state_t           state_q, state_d;
   logic             clr_a_f;
   logic             incr_a;
   logic             load_e;
   logic             set_f;
   logic             match_s;
   logic [WIDTH-1:0] a_s;
   logic             e_s;
   logic             f_s;

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath strobe decode; abort beats hold beats count.
   always_comb begin
      state_d = state_q;
      clr_a_f = 1'b0;
      incr_a  = 1'b0;
      load_e  = 1'b0;
      set_f   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               clr_a_f = 1'b1;
               state_d = S_COUNT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_COUNT: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (bus.hold) begin
               state_d = S_COUNT;
            end else begin
               incr_a = 1'b1;
               load_e = 1'b1;
               if (match_s) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_COUNT;
               end
            end
         end
         S_DONE: begin
            set_f   = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   asmd_count_dp #(
      .WIDTH (WIDTH),
      .E_BIT (E_BIT)
   ) u_dp (
      .clk         (clk),
      .rst_b       (rst_b),
      .clr_a_f_i   (clr_a_f),
      .incr_a_i    (incr_a),
      .load_e_i    (load_e),
      .set_f_i     (set_f),
      .term_mask_i (bus.term_mask),
      .a_o         (a_s),
      .e_o         (e_s),
      .f_o         (f_s),
      .match_o     (match_s)
   );

   // Status is a pure decode of the state register, so it is glitch-free.
   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = (state_q == S_DONE);
   assign bus.a    = a_s;
   assign bus.e    = e_s;
   assign bus.f    = f_s;

endmodule

// File: tb/tb_asmd_count_ctrl.sv
// Bench for asmd_count_ctrl: a 4-bit and an 8-bit instance driven from one
// stimulus process; a run-level reference model pushes the expected outputs
// of every cycle into per-instance queues that a negedge monitor drains.
module tb_asmd_count_ctrl;

   localparam int EB = 2;

   logic clk;
   logic rst_b;

   asmd_count_ctrl_if #(.WIDTH(4)) bus4 ();
   asmd_count_ctrl_if #(.WIDTH(8)) bus8 ();

   asmd_count_ctrl #(.WIDTH(4), .E_BIT(EB)) u_dut4 (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus4)
   );

   asmd_count_ctrl #(.WIDTH(8), .E_BIT(EB)) u_dut8 (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus8)
   );

   // phase: 0 waiting for start, 1 counting, 2 reporting completion
   typedef struct {
      int phase;
      int a;
      int e;
      int f;
      int mask;
   } mdl_t;

   typedef struct {
      int a;
      int e;
      int f;
      int busy;
      int done;
   } exp_t;

   mdl_t m4, m8;
   exp_t q4[$];
   exp_t q8[$];
   exp_t x4, x8;
   int   checks   = 0;
   int   failures = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: a run counts up from zero and the first value covering the
   // mask is the mask itself, so the run ends on the cycle that counts it.
   function automatic mdl_t ref_step(input mdl_t m, input int width, input int st,
                                     input int ab, input int hd, input int tm);
      mdl_t r;
      r = m;
      if (m.phase == 0) begin
         if (st != 0) begin
            r.phase = 1;
            r.a     = 0;
            r.f     = 0;
            r.mask  = tm;
         end
      end else if (m.phase == 1) begin
         if (ab != 0) begin
            r.phase = 0;
         end else if (hd == 0) begin
            r.e = (m.a >> EB) & 1;
            r.a = (m.a + 1) % (1 << width);
            if (m.a == m.mask) r.phase = 2;
         end
      end else begin
         r.f     = 1;
         r.phase = 0;
      end
      return r;
   endfunction

   function automatic exp_t view(input mdl_t m);
      exp_t r;
      r.a    = m.a;
      r.e    = m.e;
      r.f    = m.f;
      r.busy = (m.phase != 0) ? 1 : 0;
      r.done = (m.phase == 2) ? 1 : 0;
      return r;
   endfunction

   task automatic check(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
      end
   endtask

   // One clock: advance both models with the inputs the DUTs sample.
   task automatic tick();
      @(posedge clk);
      m4 = ref_step(m4, 4, int'(bus4.start), int'(bus4.abort), int'(bus4.hold),
                    int'(bus4.term_mask));
      q4.push_back(view(m4));
      m8 = ref_step(m8, 8, int'(bus8.start), int'(bus8.abort), int'(bus8.hold),
                    int'(bus8.term_mask));
      q8.push_back(view(m8));
      #1;
   endtask

   task automatic idle_all();
      bus4.start = 1'b0;
      bus4.abort = 1'b0;
      bus4.hold  = 1'b0;
      bus8.start = 1'b0;
      bus8.abort = 1'b0;
      bus8.hold  = 1'b0;
   endtask

   // Ticks until done is seen; lat0 cycles have already elapsed since accept.
   task automatic wait_done(input bit w8, input int lat0, input int want, input string name);
      int lat;
      lat = lat0;
      while (((w8 ? bus8.done : bus4.done) !== 1'b1) && (lat < 600)) begin
         tick();
         lat++;
      end
      check(name, lat, want);
   endtask

   task automatic start4(input logic [3:0] mk);
      bus4.term_mask = mk;
      bus4.start     = 1'b1;
      tick();
      bus4.start     = 1'b0;
   endtask

   task automatic start8(input logic [7:0] mk);
      bus8.term_mask = mk;
      bus8.start     = 1'b1;
      tick();
      bus8.start     = 1'b0;
   endtask

   // Monitor: compare each cycle's outputs against the queued expectation.
   always @(negedge clk) begin
      if (q4.size() > 0) begin
         x4 = q4.pop_front();
         check("mon4_a",    int'(bus4.a),    x4.a);
         check("mon4_e",    int'(bus4.e),    x4.e);
         check("mon4_f",    int'(bus4.f),    x4.f);
         check("mon4_busy", int'(bus4.busy), x4.busy);
         check("mon4_done", int'(bus4.done), x4.done);
      end
      if (q8.size() > 0) begin
         x8 = q8.pop_front();
         check("mon8_a",    int'(bus8.a),    x8.a);
         check("mon8_e",    int'(bus8.e),    x8.e);
         check("mon8_f",    int'(bus8.f),    x8.f);
         check("mon8_busy", int'(bus8.busy), x8.busy);
         check("mon8_done", int'(bus8.done), x8.done);
      end
   end

   initial begin
      idle_all();
      bus4.term_mask = 4'h0;
      bus8.term_mask = 8'h00;
      rst_b = 1'b0;
      m4 = '{default: 0};
      m8 = '{default: 0};
      #12;
      check("rst_a4",    int'(bus4.a),    0);
      check("rst_e4",    int'(bus4.e),    0);
      check("rst_f4",    int'(bus4.f),    0);
      check("rst_busy4", int'(bus4.busy), 0);
      check("rst_done4", int'(bus4.done), 0);
      check("rst_a8",    int'(bus8.a),    0);
      rst_b = 1'b1;

      // Mask 1100: thirteen counting cycles, ends with A=13, E=1.
      start4(4'b1100);
      wait_done(1'b0, 0, 13, "s1_latency");
      check("s1_a", int'(bus4.a), 13);
      check("s1_e", int'(bus4.e), 1);
      tick();
      check("s1_f",    int'(bus4.f),    1);
      check("s1_busy", int'(bus4.busy), 0);

      // 8-bit: empty mask ends at once, full mask wraps A.
      start8(8'h00);
      wait_done(1'b1, 0, 1, "s2_lat_zero");
      check("s2_a_zero", int'(bus8.a), 1);
      tick();
      start8(8'hFF);
      wait_done(1'b1, 0, 256, "s2_lat_full");
      check("s2_a_full", int'(bus8.a), 0);
      tick();
      check("s2_f_full", int'(bus8.f), 1);

      // Hold five cycles at A=4 delays done by five.
      start4(4'b1100);
      repeat (4) tick();
      bus4.hold = 1'b1;
      repeat (5) tick();
      check("s3_held_a", int'(bus4.a), 4);
      bus4.hold = 1'b0;
      wait_done(1'b0, 9, 18, "s3_latency");
      tick();
      // Abort together with hold at A=6.
      start4(4'b1100);
      repeat (6) tick();
      bus4.abort = 1'b1;
      bus4.hold  = 1'b1;
      tick();
      bus4.abort = 1'b0;
      bus4.hold  = 1'b0;
      check("s3_abort_busy", int'(bus4.busy), 0);
      check("s3_abort_a",    int'(bus4.a),    6);
      check("s3_abort_f",    int'(bus4.f),    0);
      repeat (3) tick();

      // Mask change and a second start during the run are both ignored.
      start4(4'b1100);
      bus4.term_mask = 4'b0001;
      repeat (3) tick();
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      wait_done(1'b0, 4, 13, "s4_latency");
      check("s4_a", int'(bus4.a), 13);
      tick();

      // Asynchronous reset mid-cycle at A=7, then a short run.
      start4(4'b1100);
      repeat (7) tick();
      @(negedge clk);
      #1;
      rst_b = 1'b0;
      #1;
      check("s5_rst_a",    int'(bus4.a),    0);
      check("s5_rst_e",    int'(bus4.e),    0);
      check("s5_rst_f",    int'(bus4.f),    0);
      check("s5_rst_busy", int'(bus4.busy), 0);
      m4 = '{default: 0};
      m8 = '{default: 0};
      repeat (2) @(posedge clk);
      #3;
      rst_b = 1'b1;
      start4(4'b0011);
      wait_done(1'b0, 0, 4, "s5_latency");
      check("s5_a", int'(bus4.a), 4);
      tick();

      // Start held high: back-to-back runs, checked cycle by cycle.
      bus4.term_mask = 4'b0011;
      bus4.start     = 1'b1;
      repeat (20) tick();
      bus4.start = 1'b0;
      repeat (8) tick();

      // Random traffic on both instances.
      repeat (400) begin
         bus4.start     = ($urandom_range(0, 2) == 0);
         bus4.abort     = ($urandom_range(0, 19) == 0);
         bus4.hold      = ($urandom_range(0, 3) == 0);
         bus4.term_mask = 4'($urandom_range(0, 15));
         bus8.start     = ($urandom_range(0, 3) == 0);
         bus8.abort     = ($urandom_range(0, 29) == 0);
         bus8.hold      = ($urandom_range(0, 3) == 0);
         bus8.term_mask = 8'($urandom_range(0, 63));
         tick();
      end
      idle_all();
      repeat (300) tick();

      @(negedge clk);
      #1;
      check("queues_drained", q4.size() + q8.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/asmd_count_ctrl.md
Name: asmd_count_ctrl

Overview:
Parametrised successor to the three-state start/count/flag ASMD controller. It integrates the controller and its datapath: a WIDTH-bit counter A, a sampled-bit flag E and a completion flag F.
- Termination uses a run-time bit mask latched at start, instead of fixed counter bits.
- Adds abort, hold/stall, busy and a one-cycle done strobe.
- Sits under a host sequencer that issues start and waits for done.

Parameters:
WIDTH, 4, counter A width; legal range 2..16.
E_BIT, 2, index of the A bit copied into E on each count cycle; must be < WIDTH (elaboration-time assertion).

Ports:
clk  input  1  rising-edge clock.
rst_b  input  1  reset; asynchronous, active-low.
start  input  1  begin a run; sampled only in S_IDLE.
abort  input  1  synchronous run cancel; acts in S_COUNT only.
hold  input  1  stall counting; acts in S_COUNT only.
term_mask  input  WIDTH  termination mask; captured on accepted start.
a  output  WIDTH  counter A (registered).
e  output  1  flag E (registered).
f  output  1  flag F, completion (registered).
busy  output  1  high in S_COUNT and S_DONE.
done  output  1  high for exactly the single S_DONE cycle.

Behaviour:
Reset (rst_b low, asynchronous):
- state=S_IDLE; a=0, e=0, f=0, mask_q=0.
- busy and done are decoded from state, so both read 0.

S_IDLE:
- busy=0.
- If start=1: a<=0, f<=0, mask_q<=term_mask, go to S_COUNT.
- e is not cleared by start; it holds its previous value.
- If start=0: all registers hold.

S_COUNT (busy=1). Priority is abort > hold > count.
- abort=1: go to S_IDLE. a, e and f hold; f stays 0.
- else hold=1: all registers and state hold.
- else:
  - a<=a+1, modulo 2^WIDTH.
  - e<=a[E_BIT], using the pre-increment value.
  - If (a & mask_q)==mask_q on the pre-increment value, go to S_DONE; otherwise stay in S_COUNT.

S_DONE:
- busy=1, done=1, f<=1; next state is S_IDLE unconditionally.
- a and e hold.
- start, abort and hold are ignored.

Boundary conditions and timing:
- term_mask changes during a run have no effect; only mask_q is used.
- mask_q=0 matches on the first count cycle: one S_COUNT cycle, a=1 at S_DONE.
- mask all-ones terminates at pre-increment a=2^WIDTH-1; a wraps to 0.
- Every mask is reachable, so the count never hangs without hold.
- Latency with no holds, where n = smallest value with (n & mask)==mask:
  - S_COUNT lasts n+1 cycles.
  - done rises n+1 cycles after the start-accept edge.
  - f reads 1 from the first S_IDLE cycle after S_DONE.
- Each hold cycle adds exactly one cycle of latency.
- start asserted while busy is ignored. It is not queued.
- start held high continuously restarts a run on the first S_IDLE cycle after S_DONE; f is cleared at that edge.
- rst_b asserted mid-run forces reset values immediately, regardless of clk.

Decomposition:
- Package asmd_count_pkg holds:
  - state_t enum {S_IDLE, S_COUNT, S_DONE}, 2-bit, binary encoded.
  - localparam encodings.
  - An E_BIT/WIDTH range-check function.
- One sub-module, asmd_count_dp: the datapath, holding a, e, f and mask_q, driven by the decoded control strobes clr_a_f, incr_a, load_e and set_f.
- The top module keeps the state register and next-state/output decode.

Test Plan:
1. WIDTH=4, E_BIT=2, term_mask=4'b1100, start one cycle, no hold/abort -> 13 S_COUNT cycles, done pulses once, a=13, e=1, f=1, busy drops the cycle after done.
2. WIDTH=8, term_mask=8'h00 -> one S_COUNT cycle, a=8'h01, done one cycle after start accept. Then term_mask=8'hFF -> 256 S_COUNT cycles, a=8'h00 (wrap), f=1.
3. WIDTH=4, mask 4'b1100, hold high for 5 cycles while a=4, and abort simultaneously at a=6 in a second run:
   - First run: done 5 cycles later than scenario 1; a never advances while held.
   - Second run: abort wins over hold; state S_IDLE next, a=6, f=0, done never asserted.
4. Change term_mask from 4'b1100 to 4'b0001 one cycle after start; pulse start again at a=3 -> run still ends at a=13; the second start has no effect.
5. Assert rst_b low asynchronously mid-cycle at a=7 -> a=0, e=0, f=0, busy=0 immediately, before the next clk edge. Then release rst_b and start with mask 4'b0011 -> done after 4 S_COUNT cycles, a=4.
6. Hold start high continuously -> back-to-back runs. f=1 for exactly one S_IDLE cycle between runs, and a clears to 0 on each restart.
